// File: rtl/rate_div_pkg.sv
// Shared constants and state encoding for the rate divider sequencer.
package rate_div_pkg;

  localparam int RATE_W        = 2;
  localparam int DEF_DIV_W     = 26;
  localparam int DEF_RATE0_DIV = 1;
  localparam int DEF_RATE1_DIV = 50_000_000;
  localparam int DEF_RATE2_DIV = 25_000_000;
  localparam int DEF_RATE3_DIV = 12_500_000;

  // PENDING means the sequencer is running and a rate change is queued
  // for the next tick boundary.
  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PENDING = 2'd2
  } state_e;

endpackage

// File: rtl/rate_divider_ctrl_tick_gen.sv
// Loadable down-counter; terminal count (cnt==0) marks a tick boundary.
import rate_div_pkg::*;

module rate_tick_gen #(
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic             clock,
  input  logic             clear_b,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [DIV_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_tc
);

  logic [DIV_W-1:0] r_cnt;

  // Clear wins over load, load wins over decrement.
  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b)    r_cnt <= '0;
    else if (i_clr)  r_cnt <= '0;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_dec)  r_cnt <= r_cnt - 1'b1;
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/rate_divider_ctrl.sv
// Rate-selectable tick sequencer with glitch-free rate changes and digit tracking.
import rate_div_pkg::*;

module rate_divider_ctrl #(
  parameter int          DIV_W      = DEF_DIV_W,
  parameter int unsigned RATE0_DIV  = DEF_RATE0_DIV,
  parameter int unsigned RATE1_DIV  = DEF_RATE1_DIV,
  parameter int unsigned RATE2_DIV  = DEF_RATE2_DIV,
  parameter int unsigned RATE3_DIV  = DEF_RATE3_DIV,
  parameter logic [RATE_W-1:0] RESET_RATE = 2'd1
) (
  input  logic              clock,
  input  logic              clear_b,
  input  logic              start,
  input  logic              stop,
  input  logic              rate_req,
  input  logic [RATE_W-1:0] rate_sel,
  output logic              rate_ack,
  output logic [RATE_W-1:0] rate_active,
  output logic              tick,
  output logic [3:0]        digit,
  output logic              wrap,
  output logic              running
);

  // Reload value is one less than the divisor: the terminal-count cycle is
  // itself part of the period.
  function automatic logic [DIV_W-1:0] div_m1(input logic [RATE_W-1:0] r);
    case (r)
      2'd0:    return DIV_W'(RATE0_DIV - 1);
      2'd1:    return DIV_W'(RATE1_DIV - 1);
      2'd2:    return DIV_W'(RATE2_DIV - 1);
      default: return DIV_W'(RATE3_DIV - 1);
    endcase
  endfunction

  state_e            r_state, w_state_nx;
  logic [RATE_W-1:0] r_rate, w_rate_nx;
  logic [RATE_W-1:0] r_pend, w_pend_nx;
  logic [3:0]        r_digit, w_digit_nx;
  logic              r_tick, w_tick_nx;
  logic              r_wrap, w_wrap_nx;
  logic              r_ack, w_ack_nx;
  logic              r_running;

  logic              w_tc, w_clr, w_load, w_dec;
  logic [DIV_W-1:0]  w_load_val;
  logic              w_has_pend;
  logic [RATE_W-1:0] w_pend_val;

  rate_tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
    .clock      (clock),
    .clear_b    (clear_b),
    .i_clr      (w_clr),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_tc       (w_tc)
  );

  // A request on the current edge merges with any queued one (last wins).
  assign w_has_pend = rate_req || (r_state == ST_PENDING);
  assign w_pend_val = rate_req ? rate_sel : r_pend;

  // Next-state, rate application and counter control.
  always_comb begin
    w_state_nx = r_state;
    w_rate_nx  = r_rate;
    w_pend_nx  = r_pend;
    w_digit_nx = r_digit;
    w_tick_nx  = 1'b0;
    w_wrap_nx  = 1'b0;
    w_ack_nx   = 1'b0;
    w_clr      = 1'b0;
    w_load     = 1'b0;
    w_dec      = 1'b0;
    case (r_state)
      ST_STOPPED: begin
        // No tick boundary to wait for: requests apply at once.
        if (rate_req) begin
          w_rate_nx = rate_sel;
          w_ack_nx  = 1'b1;
        end
        if (stop) begin
          w_clr = 1'b1;
        end else if (start) begin
          w_state_nx = ST_RUNNING;
          w_digit_nx = 4'd0;
          w_load     = 1'b1;
        end
      end
      ST_RUNNING, ST_PENDING: begin
        if (stop) begin
          w_state_nx = ST_STOPPED;
          w_clr      = 1'b1;
          if (w_has_pend) begin
            w_rate_nx = w_pend_val;
            w_ack_nx  = 1'b1;
          end
        end else if (w_tc) begin
          w_state_nx = ST_RUNNING;
          w_tick_nx  = 1'b1;
          w_wrap_nx  = (r_digit == 4'hF);
          w_digit_nx = r_digit + 4'd1;
          w_load     = 1'b1;
          if (w_has_pend) begin
            w_rate_nx = w_pend_val;
            w_ack_nx  = 1'b1;
          end
        end else begin
          w_dec = 1'b1;
          if (rate_req) begin
            w_pend_nx  = rate_sel;
            w_state_nx = ST_PENDING;
          end
        end
      end
      default: begin
        w_state_nx = ST_STOPPED;
        w_clr      = 1'b1;
      end
    endcase
  end

  // Reload always uses the rate in force after this edge.
  assign w_load_val = div_m1(w_rate_nx);

  // State and registered outputs.
  always_ff @(posedge clock or negedge clear_b) begin
    if (!clear_b) begin
      r_state   <= ST_STOPPED;
      r_rate    <= RESET_RATE;
      r_pend    <= '0;
      r_digit   <= 4'd0;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
      r_ack     <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_rate    <= w_rate_nx;
      r_pend    <= w_pend_nx;
      r_digit   <= w_digit_nx;
      r_tick    <= w_tick_nx;
      r_wrap    <= w_wrap_nx;
      r_ack     <= w_ack_nx;
      r_running <= (w_state_nx != ST_STOPPED);
    end
  end

  assign rate_ack    = r_ack;
  assign rate_active = r_rate;
  assign tick        = r_tick;
  assign digit       = r_digit;
  assign wrap        = r_wrap;
  assign running     = r_running;

endmodule

// File: tb/tb_rate_divider_ctrl.sv
// Scoreboard bench for rate_divider_ctrl with divisors 1/3/4/6.
module tb_rate_divider_ctrl;

  logic       clock, clear_b, start, stop, rate_req;
  logic [1:0] rate_sel, rate_active;
  logic       rate_ack, tick, wrap, running;
  logic [3:0] digit;

  typedef struct packed {
    logic       tick;
    logic       wrap;
    logic       ack;
    logic [3:0] digit;
    logic [1:0] rate;
    logic       run;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: absolute edge numbers instead of a down-counter.
  int         div_tab[4] = '{1, 3, 4, 6};
  bit         m_run, m_pv;
  logic [1:0] m_rate, m_pend;
  int         m_digit;
  longint     m_edge = 0;
  longint     m_next = 0;
  exp_t       m_out;

  rate_divider_ctrl #(
    .DIV_W(26), .RATE0_DIV(1), .RATE1_DIV(3), .RATE2_DIV(4), .RATE3_DIV(6),
    .RESET_RATE(2'd1)
  ) dut (
    .clock(clock), .clear_b(clear_b), .start(start), .stop(stop),
    .rate_req(rate_req), .rate_sel(rate_sel), .rate_ack(rate_ack),
    .rate_active(rate_active), .tick(tick), .digit(digit), .wrap(wrap),
    .running(running)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic exp_t snap();
    exp_t o;
    o.tick = 1'b0; o.wrap = 1'b0; o.ack = 1'b0;
    o.digit = 4'(m_digit); o.rate = m_rate; o.run = m_run;
    return o;
  endfunction

  task automatic model_reset();
    m_run = 0; m_pv = 0; m_rate = 2'd1; m_pend = 2'd0; m_digit = 0;
    m_out = snap();
  endtask

  task automatic model_edge(input bit st, input bit sp, input bit rq, input logic [1:0] sl);
    bit t, w, a;
    t = 0; w = 0; a = 0;
    m_edge++;
    if (!m_run) begin
      if (rq) begin m_rate = sl; a = 1; end
      if (!sp && st) begin
        m_run = 1; m_digit = 0; m_next = m_edge + div_tab[m_rate];
      end
    end else begin
      if (rq) begin m_pend = sl; m_pv = 1; end
      if (sp) begin
        m_run = 0;
        if (m_pv) begin m_rate = m_pend; m_pv = 0; a = 1; end
      end else if (m_edge == m_next) begin
        t = 1; w = (m_digit == 15); m_digit = (m_digit + 1) % 16;
        if (m_pv) begin m_rate = m_pend; m_pv = 0; a = 1; end
        m_next = m_edge + div_tab[m_rate];
      end
    end
    m_out = snap();
    m_out.tick = t; m_out.wrap = w; m_out.ack = a;
  endtask

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, want);
    end
  endtask

  function automatic exp_t dut_out();
    exp_t o;
    o.tick = tick; o.wrap = wrap; o.ack = rate_ack; o.digit = digit;
    o.rate = rate_active; o.run = running;
    return o;
  endfunction

  // One clock of stimulus: drive at the falling edge, predict the next edge.
  task automatic cyc(input bit clr_n, input bit st, input bit sp, input bit rq,
                     input logic [1:0] sl);
    bit was;
    @(negedge clock);
    start = st; stop = sp; rate_req = rq; rate_sel = sl;
    if (!clr_n) begin
      was = clear_b;
      clear_b = 1'b0;
      model_reset();
      if (was) begin
        #1;
        chk("clear_async", int'(dut_out()), int'(m_out));
      end
    end else begin
      clear_b = 1'b1;
      model_edge(st, sp, rq, sl);
    end
    q.push_back(m_out);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 2'd0);
  endtask

  // Monitor: compares every presented output cycle against the scoreboard.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clock);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        a = dut_out();
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL cycle_out t=%0t got=%h want=%h (tick,wrap,ack,digit,rate,run)",
                   $time, a, e);
        end
      end
    end
  end

  initial begin
    start = 0; stop = 0; rate_req = 0; rate_sel = 2'd0;
    clear_b = 1'b1;
    model_reset();
    #1 clear_b = 1'b0;
    #1;
    chk("reset_state", int'(dut_out()), int'(m_out));
    chk("reset_rate", int'(rate_active), 1);
    cyc(0, 0, 0, 0, 2'd0);

    // 1: start, first tick DIV=3 edges later with digit 1
    cyc(1, 0, 0, 0, 2'd0);
    cyc(1, 1, 0, 0, 2'd0);
    idle(4);
    chk("first_tick", int'(tick), 1);
    chk("first_digit", int'(digit), 1);

    // 2: run through a full digit wrap
    idle(50);

    // 3: rate change mid-period
    idle(1);
    cyc(1, 0, 0, 1, 2'd2);
    idle(20);
    chk("s3_rate", int'(rate_active), 2);

    // 4: two requests merged before the boundary
    cyc(1, 0, 0, 1, 2'd2);
    cyc(1, 0, 0, 1, 2'd3);
    idle(30);
    chk("s4_rate", int'(rate_active), 3);

    // 5: stop; start+stop together while stopped; stop at DIV=1
    cyc(1, 0, 1, 0, 2'd0);
    cyc(1, 1, 1, 0, 2'd0);
    idle(1);
    chk("startstop_run", int'(running), 0);
    chk("startstop_tick", int'(tick), 0);
    cyc(1, 0, 0, 1, 2'd0);
    cyc(1, 1, 0, 0, 2'd0);
    idle(5);
    cyc(1, 0, 1, 0, 2'd0);
    idle(1);
    chk("stop_tick", int'(tick), 0);
    chk("stop_run", int'(running), 0);
    idle(3);

    // 6: clear while a rate change is pending
    cyc(1, 0, 0, 1, 2'd1);
    cyc(1, 1, 0, 0, 2'd0);
    idle(1);
    cyc(1, 0, 0, 1, 2'd2);
    cyc(0, 0, 0, 0, 2'd0);
    chk("clear_rate", int'(rate_active), 1);
    cyc(0, 0, 0, 0, 2'd0);
    idle(10);

    // Random phase
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 199) != 0),
          ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 7) == 0),
          2'($urandom_range(0, 3)));
    end
    idle(3);
    @(posedge clock);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
